// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: framer state encoding,
// parity-type constants and the legal parameter ranges.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for one UART data word; even parity makes
// the total count of ones (data + parity) even, odd parity makes it odd.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        parity_bit = ^data;
        case (par_typ)
            PAR_EVEN: parity_bit = ^data;
            PAR_ODD:  parity_bit = ~^data;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: accepts a word on a valid/ready handshake and shifts
// out start, data (LSB first), optional parity and stop bits from a flop.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        CLKS_PER_BIT < 1) begin : g_bad_params
        $error("uart_tx_frame: parameter out of legal range");
    end

    tx_state_t             state;
    logic [TMR_W-1:0]      bit_tmr;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  parity_bit;
    logic                  bit_done;

    assign bit_done = (bit_tmr == LAST_TICK);
    assign next_cnt = bit_cnt + 1'b1;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data       (data_q),
        .par_typ    (par_typ_q),
        .parity_bit (parity_bit)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of state, bit_tmr and bit_cnt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bit_tmr    <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            TX_OUT     <= 1'b1;
            BUSY       <= 1'b0;
            DATA_READY <= 1'b1;
        end else begin
            if (state != IDLE) begin
                bit_tmr <= bit_done ? '0 : bit_tmr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (DATA_VALID) begin
                        data_q     <= P_DATA;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        bit_tmr    <= '0;
                        bit_cnt    <= '0;
                        state      <= START;
                        TX_OUT     <= 1'b0;
                        BUSY       <= 1'b1;
                        DATA_READY <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state  <= DATA;
                        TX_OUT <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= parity_bit;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= next_cnt;
                            TX_OUT  <= data_q[next_cnt];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                STOP: begin
                    // bit_cnt is reused here to count stop bits
                    if (bit_done) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt    <= '0;
                            state      <= IDLE;
                            BUSY       <= 1'b0;
                            DATA_READY <= 1'b1;
                        end else begin
                            bit_cnt <= next_cnt;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    TX_OUT     <= 1'b1;
                    BUSY       <= 1'b0;
                    DATA_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations share one stimulus stream and
// are compared every cycle against a queue-of-line-levels reference model.
module tb_uart_tx_frame;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;

    logic tx_a, busy_a, ready_a;
    logic tx_b, busy_b, ready_b;
    logic tx_c, busy_c, ready_c;

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;

    // Expected line level per cycle; empty queue means idle.
    bitq_t q_a, q_b, q_c;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
        .DATA_READY(ready_a), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx_a), .BUSY(busy_a)
    );

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
        .DATA_READY(ready_b), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx_b), .BUSY(busy_b)
    );

    uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_c (
        .CLK(clk), .RST(rst), .P_DATA(p_data[4:0]), .DATA_VALID(data_valid),
        .DATA_READY(ready_c), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx_c), .BUSY(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bitq_t build(input logic [8:0] data, input int dw, input int cpb,
                                    input int sb, input logic pe, input logic pt);
        bitq_t lv;
        bit    bits[$];
        int    ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pe) bits.push_back(bit'(ones % 2) ^ pt);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        foreach (bits[k]) repeat (cpb) lv.push_back(bits[k]);
        return lv;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
            q_c.delete();
        end else begin
            if (q_a.size() != 0) void'(q_a.pop_front());
            else if (data_valid) q_a = build({1'b0, p_data}, 8, 4, 1, par_en, par_typ);
            if (q_b.size() != 0) void'(q_b.pop_front());
            else if (data_valid) q_b = build({1'b0, p_data}, 8, 4, 2, par_en, par_typ);
            if (q_c.size() != 0) void'(q_c.pop_front());
            else if (data_valid) q_c = build({1'b0, p_data}, 5, 1, 1, par_en, par_typ);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_tx",    tx_a,    (q_a.size() != 0) ? q_a[0] : 1'b1);
            check("a_busy",  busy_a,  q_a.size() != 0);
            check("a_ready", ready_a, q_a.size() == 0);
            check("b_tx",    tx_b,    (q_b.size() != 0) ? q_b[0] : 1'b1);
            check("b_busy",  busy_b,  q_b.size() != 0);
            check("b_ready", ready_b, q_b.size() == 0);
            check("c_tx",    tx_c,    (q_c.size() != 0) ? q_c[0] : 1'b1);
            check("c_busy",  busy_c,  q_c.size() != 0);
            check("c_ready", ready_c, q_c.size() == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ready_a && ready_b && ready_c) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("idle_timeout", 0, 1);
    endtask

    // One-cycle valid pulse, then count busy cycles per configuration.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input bit scramble);
        int na = 0, nb = 0, nc = 0, cyc = 0;
        wait_idle();
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        do begin
            @(negedge clk);
            na += int'(busy_a);
            nb += int'(busy_b);
            nc += int'(busy_c);
            cyc++;
            if (scramble && cyc == 3) begin
                p_data = ~d; par_en = ~pe; par_typ = ~pt;
            end
        end while ((busy_a || busy_b || busy_c) && cyc < 400);
        check("len_a", na, 4 * (1 + 8 + int'(pe) + 1));
        check("len_b", nb, 4 * (1 + 8 + int'(pe) + 2));
        check("len_c", nc, 1 + 5 + int'(pe) + 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdy_a = 0, rdy_b = 0;

        rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        send(8'hA5, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b0, 1'b0);
        send(8'h15, 1'b0, 1'b0, 1'b0);

        // Back-to-back: 0xFF offered and held while 0x3C is on the line.
        wait_idle();
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        p_data = 8'hFF;
        repeat (60) begin
            @(negedge clk);
            rdy_a += int'(ready_a);
            rdy_b += int'(ready_b);
        end
        check("b2b_gap_a", rdy_a, 1);
        check("b2b_gap_b", rdy_b, 1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        wait_idle();

        // Reset at cycle 10 of a 0x00 frame, with a word offered on the reset edge.
        p_data = 8'h00; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1; data_valid = 1'b1; p_data = 8'h55;
        tick();
        rst = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        check("rst_tx",    tx_a,    1'b1);
        check("rst_busy",  busy_a,  1'b0);
        check("rst_ready", ready_a, 1'b1);
        @(posedge clk);
        #1;
        send(8'h55, 1'b0, 1'b0, 1'b0);

        // Random words, parity modes and mid-frame input changes.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        wait_idle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer: accepts a parallel word over a valid/ready handshake and serialises it on `TX_OUT` as start bit, data bits LSB first, optional parity bit and one or two stop bits, holding each bit for a programmable number of clock cycles. It replaces the fixed-width serializer/mux/output-register path of the UART TX with one self-timed block. It sits between the TX data source (register file or FIFO) and the UART pad.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data bits per frame, legal range 5..9.
- `CLKS_PER_BIT`, 16: `CLK` cycles per bit, ≥1. 1 means one bit per clock.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `CLK`  in  1  single clock for all logic.
- `RST`  in  1  reset: synchronous, active-high.
- `P_DATA`  in  DATA_WIDTH  word to transmit.
- `DATA_VALID`  in  1  source offers `P_DATA`.
- `DATA_READY`  out  1  framer can accept a word.
- `PAR_EN`  in  1  1 = insert parity bit.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `TX_OUT`  out  1  serial line, registered, idles high.
- `BUSY`  out  1  high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `DATA_READY`=1, `BUSY`=0, `TX_OUT`=1. Acceptance is `DATA_VALID && DATA_READY`. On acceptance, latch `P_DATA`, `PAR_EN` and `PAR_TYP`, go to START.
- START drives 0. DATA drives latched bits 0..DATA_WIDTH-1, LSB first. PARITY is entered only if latched `PAR_EN`=1; it drives the XOR of the data for even parity, or its inverse for odd. STOP drives 1 for STOP_BITS bit times, then returns to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1. The state or bit index advances when the timer reaches CLKS_PER_BIT-1. A bit counter (width $clog2(DATA_WIDTH)) indexes DATA and counts stop bits.
- Inputs sampled outside IDLE have no effect. `DATA_VALID` while busy is ignored; the source must hold it. Changing `PAR_EN`/`PAR_TYP` mid-frame does not affect the current frame.
- `BUSY` = (state ≠ IDLE). `DATA_READY` = (state == IDLE). Both are registered with the state.
- Reset values: state IDLE, `TX_OUT`=1, `BUSY`=0, `DATA_READY`=1, all counters and the data latch 0.
- Reset mid-frame: on the next `CLK` edge the frame is aborted, `TX_OUT`=1 and the block is in IDLE. No partial completion.
- Simultaneous `RST` and `DATA_VALID`: reset wins; the word is not accepted.

## Timing
- Acceptance at edge N: `TX_OUT`=0 and `BUSY`=1 from edge N+1.
- Frame length is CLKS_PER_BIT × (1 + DATA_WIDTH + PAR_EN + STOP_BITS) cycles. After that, the block is in IDLE with `DATA_READY`=1.
- Back-to-back frames: the minimum gap is one `CLK` cycle of IDLE (`TX_OUT`=1) between the last stop-bit cycle and the next start bit.
- All outputs come straight from flops. There is no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`: the state enum (IDLE/START/DATA/PARITY/STOP), `PAR_EVEN`/`PAR_ODD` constants, the legal-range constants for DATA_WIDTH and STOP_BITS.
- One sub-module, `uart_parity_calc`: parametrised on DATA_WIDTH, with inputs data and type and output parity bit. It is combinational and evaluated on the latched word.
- The FSM, bit timer, bit counter and output register stay in the top.

## Test plan
All scenarios use DATA_WIDTH=8 and CLKS_PER_BIT=4 unless stated otherwise.
- 0xA5, `PAR_EN`=0, STOP_BITS=1 -> `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1, each bit held for 4 cycles. `BUSY` is high for 40 cycles and `DATA_READY` returns to 1 afterwards.
- 0xA5, `PAR_EN`=1 -> parity bit 0 with `PAR_TYP`=0, and 1 with `PAR_TYP`=1. The frame is 44 cycles.
- 0x80, `PAR_EN`=1, `PAR_TYP`=0, STOP_BITS=2 -> data bits 0,0,0,0,0,0,0,1, parity 1, two stop bits. The frame is 48 cycles.
- 0x3C accepted, then 0xFF presented with `DATA_VALID` held during the frame -> 0xFF is not accepted until IDLE. Its start bit appears exactly 1 cycle after the last stop-bit cycle of 0x3C. The 0x3C bits are unchanged.
- `RST` asserted at cycle 10 of a 0x00 frame -> `TX_OUT`=1, `BUSY`=0, `DATA_READY`=1 at the next edge. The next accepted 0x55 produces a clean full frame.
- CLKS_PER_BIT=1, DATA_WIDTH=5, 0x15, `PAR_EN`=0 -> `TX_OUT` is 0,1,0,1,0,1,1, one cycle per bit.
